// File: rtl/alu_entry_sequencer.sv
// Keypad-entry sequencer and ALU launch/capture controller for the calculator datapath.
// Optional feature: define ALU_RESULT_CHAIN_EN so that EXE in GOP chains the last result into A.
module alu_entry_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [4:0]       valor,
  input  logic             BTNC,
  input  logic [1:0]       estado_alu,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [WIDTH-1:0] display_value
);

  localparam int DIGITS = WIDTH / 4;
  localparam int CW     = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] FULL    = CW'(DIGITS);
  localparam logic [4:0]    KEY_EXE = 5'b10011;
  localparam logic [4:0]    KEY_CLR = 5'b10111;
  localparam logic [4:0]    KEY_CE  = 5'b10110;
  localparam logic [1:0]    OP_ADD  = 2'd0;

  typedef enum logic [1:0] {W1 = 2'd0, W2 = 2'd1, WOP = 2'd2, GOP = 2'd3} alu_state_t;

  alu_state_t     st;
  logic [CW-1:0]  cnt_a, cnt_b;
  logic           launch_req, drop_pending;
  logic           is_digit, is_exe, is_clr, is_ce;
  logic           locked, abort, launch_go, in_flight;

  always_comb begin
    st        = alu_state_t'(estado_alu);
    is_digit  = BTNC && !valor[4];
    is_exe    = BTNC && (valor == KEY_EXE);
    is_clr    = BTNC && (valor == KEY_CLR);
    is_ce     = BTNC && (valor == KEY_CE);
    in_flight = busy || alu_start;
    // Operands and op stay frozen from the moment a launch is requested until it resolves.
    locked    = in_flight || launch_req;
    abort     = is_clr || (is_ce && (st == GOP));
    launch_go = launch_req && !drop_pending && !in_flight;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      alu_a         <= '0;
      alu_b         <= '0;
      cnt_a         <= '0;
      cnt_b         <= '0;
      alu_op        <= OP_ADD;
      alu_start     <= 1'b0;
      busy          <= 1'b0;
      launch_req    <= 1'b0;
      drop_pending  <= 1'b0;
      result        <= '0;
      result_valid  <= 1'b0;
      display_value <= '0;
    end else begin
      alu_start <= 1'b0;
      if (launch_go && !abort) begin
        alu_start  <= 1'b1;
        launch_req <= 1'b0;
      end
      if (alu_start && !abort) busy <= 1'b1;

      // A stale completion is consumed by the drop; only a live one is captured.
      if (alu_done) begin
        if (drop_pending) begin
          drop_pending <= 1'b0;
        end else if (busy) begin
          busy <= 1'b0;
          if (!abort) begin
            result       <= alu_result;
            result_valid <= 1'b1;
          end
        end
      end

      if (abort) begin
        launch_req   <= 1'b0;
        result_valid <= 1'b0;
        if (in_flight) begin
          busy <= 1'b0;
          if (!alu_done) drop_pending <= 1'b1;
        end
      end

      if (is_clr) begin
        alu_a  <= '0;
        alu_b  <= '0;
        cnt_a  <= '0;
        cnt_b  <= '0;
        alu_op <= OP_ADD;
        result <= '0;
      end else if (is_ce) begin
        if (!locked) begin
          case (st)
            W1:  begin alu_a <= '0; cnt_a <= '0; end
            W2:  begin alu_b <= '0; cnt_b <= '0; end
            WOP: alu_op <= OP_ADD;
            default: ;
          endcase
        end
      end else if (is_exe) begin
        if (!locked) begin
          case (st)
            WOP: launch_req <= 1'b1;
            GOP: begin
`ifdef ALU_RESULT_CHAIN_EN
              if (result_valid) begin
                alu_a <= result;
                cnt_a <= FULL;
              end else begin
                alu_a <= '0;
                cnt_a <= '0;
              end
`else
              alu_a <= '0;
              cnt_a <= '0;
`endif
              alu_b        <= '0;
              cnt_b        <= '0;
              alu_op       <= OP_ADD;
              result_valid <= 1'b0;
            end
            default: ;
          endcase
        end
      end else if (is_digit && !locked) begin
        case (st)
          W1: if (cnt_a != FULL) begin
            alu_a <= {alu_a[WIDTH-5:0], valor[3:0]};
            cnt_a <= cnt_a + CW'(1);
          end
          W2: if (cnt_b != FULL) begin
            alu_b <= {alu_b[WIDTH-5:0], valor[3:0]};
            cnt_b <= cnt_b + CW'(1);
          end
          WOP: if (valor[3:2] == 2'b00) alu_op <= valor[1:0];
          default: ;
        endcase
      end

      // Display follows the FSM state seen this cycle, one cycle behind.
      case (st)
        W1:      display_value <= alu_a;
        W2:      display_value <= alu_b;
        WOP:     display_value <= {{(WIDTH-2){1'b0}}, alu_op};
        default: display_value <= result_valid ? result : '0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_entry_sequencer.sv
// Directed-vector bench for alu_entry_sequencer; a scoreboard monitor checks every launch and captured result.
module tb_alu_entry_sequencer;

  localparam logic [4:0] EXE = 5'b10011, CLR = 5'b10111, CE = 5'b10110;
  localparam logic [1:0] SW1 = 2'd0, SW2 = 2'd1, SWOP = 2'd2, SGOP = 2'd3;

  logic        clk_in = 0, reset = 1;
  logic [4:0]  valor = 0;
  logic        BTNC = 0;
  logic [1:0]  estado_alu = 0;
  logic [15:0] alu_a, alu_b, alu_result = 0, result, display_value;
  logic [1:0]  alu_op;
  logic        alu_start, alu_done = 0, busy, result_valid;

  int checks = 0, errors = 0;

  typedef struct { logic [15:0] a; logic [15:0] b; logic [1:0] op; } launch_t;
  launch_t     launch_q[$];
  logic [15:0] result_q[$];
  logic        rv_prev = 0;

  alu_entry_sequencer #(.WIDTH(16)) dut (
    .clk_in(clk_in), .reset(reset), .valor(valor), .BTNC(BTNC), .estado_alu(estado_alu),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .busy(busy), .result(result),
    .result_valid(result_valid), .display_value(display_value)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every start pulse and every rising result_valid must match a queued expectation.
  always @(negedge clk_in) begin
    launch_t     e;
    logic [15:0] r;
    if (!reset) begin
      if (alu_start) begin
        if (launch_q.size() == 0) check("unexpected_start", 1, 0);
        else begin
          e = launch_q.pop_front();
          check("launch_a", alu_a, e.a);
          check("launch_b", alu_b, e.b);
          check("launch_op", alu_op, e.op);
        end
      end
      if (result_valid && !rv_prev) begin
        if (result_q.size() == 0) check("unexpected_result", 1, 0);
        else begin
          r = result_q.pop_front();
          check("result_value", result, r);
        end
      end
    end
    rv_prev = result_valid;
  end

  task automatic press(input logic [4:0] code, input logic [1:0] s);
    estado_alu = s; valor = code; BTNC = 1;
    @(negedge clk_in);
    BTNC = 0; valor = 0;
  endtask

  task automatic pulse_done(input logic [15:0] v);
    alu_result = v; alu_done = 1;
    @(negedge clk_in);
    alu_done = 0;
  endtask

  task automatic wait_start(input int limit);
    int n = 0;
    while (!alu_start && n < limit) begin @(negedge clk_in); n++; end
    check("start_timeout", alu_start, 1);
  endtask

  task automatic push_launch(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    launch_t e;
    e.a = a; e.b = b; e.op = op;
    launch_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk_in);
    reset = 0;
    check("rst_a", alu_a, 0);           check("rst_b", alu_b, 0);
    check("rst_op", alu_op, 0);         check("rst_start", alu_start, 0);
    check("rst_busy", busy, 0);         check("rst_result", result, 0);
    check("rst_rv", result_valid, 0);   check("rst_disp", display_value, 0);

    // Digit entry saturates at four digits
    for (int d = 1; d <= 5; d++) press(5'(d), SW1);
    check("a_1234", alu_a, 16'h1234);
    @(negedge clk_in);
    check("disp_1234", display_value, 16'h1234);

    // SUB 00FF - 0001
    press(CE, SW1);
    check("a_ce", alu_a, 0);
    press(5'h0, SW1); press(5'h0, SW1); press(5'hF, SW1); press(5'hF, SW1);
    check("a_00ff", alu_a, 16'h00FF);
    press(5'h1, SW2);
    check("b_0001", alu_b, 16'h0001);
    press(5'h1, SWOP);
    check("op_sub", alu_op, 1);
    push_launch(16'h00FF, 16'h0001, 2'd1);
    press(EXE, SWOP);
    check("start_n", alu_start, 0);
    @(negedge clk_in);
    check("start_n1", alu_start, 1);
    @(negedge clk_in);
    check("start_n2", alu_start, 0);
    check("busy_n2", busy, 1);
    @(negedge clk_in);
    result_q.push_back(16'h00FE);
    pulse_done(16'h00FE);
    check("busy_done", busy, 0);
    check("rv_done", result_valid, 1);
    check("res_00fe", result, 16'h00FE);
    estado_alu = SGOP;
    @(negedge clk_in);
    check("disp_gop", display_value, 16'h00FE);

    // CE in W2 keeps A; invalid op digit ignored
    press(CLR, SGOP);
    check("clr_result", result, 0);
    check("clr_rv", result_valid, 0);
    check("clr_a", alu_a, 0);
    press(5'h1, SW1); press(5'h2, SW1);
    press(5'hA, SW2); press(5'hB, SW2);
    check("b_00ab", alu_b, 16'h00AB);
    press(CE, SW2);
    check("b_ce", alu_b, 0);
    check("a_kept", alu_a, 16'h0012);
    press(5'h3, SW1);
    check("a_append", alu_a, 16'h0123);
    press(5'h2, SWOP);
    press(5'h7, SWOP);
    check("op_keep", alu_op, 2);
    press(CE, SWOP);
    check("op_ce", alu_op, 0);

    // Abort in flight, relaunch held until the stale done is dropped
    press(CLR, SWOP);
    press(5'h2, SW1); press(5'h3, SW2);
    push_launch(16'h0002, 16'h0003, 2'd0);
    press(EXE, SWOP);
    wait_start(5);
    @(negedge clk_in);
    check("busy_abort_pre", busy, 1);
    press(CLR, SWOP);
    check("busy_abort", busy, 0);
    check("a_abort", alu_a, 0);
    press(5'h2, SW1); press(5'h3, SW2);
    push_launch(16'h0002, 16'h0003, 2'd0);
    press(EXE, SWOP);
    for (int i = 0; i < 4; i++) begin
      check("start_held", alu_start, 0);
      @(negedge clk_in);
    end
    pulse_done(16'hDEAD);
    check("stale_dropped", result_valid, 0);
    wait_start(5);
    repeat (2) @(negedge clk_in);
    result_q.push_back(16'h0005);
    pulse_done(16'h0005);
    check("rv_5", result_valid, 1);
    check("res_5", result, 16'h0005);

    // EXE in GOP
    press(5'h3, SWOP);
    check("op_or", alu_op, 3);
    press(EXE, SGOP);
    check("gop_b", alu_b, 0);
    check("gop_op", alu_op, 0);
    check("gop_rv", result_valid, 0);
`ifdef ALU_RESULT_CHAIN_EN
    check("chain_a", alu_a, 16'h0005);
    press(5'h7, SW1);
    check("chain_full", alu_a, 16'h0005);
`else
    check("gop_a", alu_a, 0);
    press(5'h7, SW1);
    check("gop_digit", alu_a, 16'h0007);
`endif

    // Done in the same cycle as abort: discarded, no drop left behind
    press(CLR, SW1);
    press(5'h1, SW1); press(5'h1, SW2);
    push_launch(16'h0001, 16'h0001, 2'd0);
    press(EXE, SWOP);
    wait_start(5);
    @(negedge clk_in);
    check("busy_same", busy, 1);
    alu_result = 16'hBEEF; alu_done = 1;
    press(CLR, SWOP);
    alu_done = 0;
    check("same_rv", result_valid, 0);
    check("same_busy", busy, 0);
    press(5'h4, SW1); press(5'h4, SW2);
    push_launch(16'h0004, 16'h0004, 2'd0);
    press(EXE, SWOP);
    check("nodrop_n", alu_start, 0);
    @(negedge clk_in);
    check("nodrop_n1", alu_start, 1);
    @(negedge clk_in);
    result_q.push_back(16'h0008);
    pulse_done(16'h0008);
    check("res_8", result, 16'h0008);

    // Async reset while busy
    press(CLR, SWOP);
    press(5'h1, SW1); press(5'h1, SW2);
    push_launch(16'h0001, 16'h0001, 2'd0);
    press(EXE, SWOP);
    wait_start(5);
    @(negedge clk_in);
    check("busy_pre_rst", busy, 1);
    #2 reset = 1;
    #1;
    check("arst_busy", busy, 0);      check("arst_a", alu_a, 0);
    check("arst_b", alu_b, 0);        check("arst_op", alu_op, 0);
    check("arst_start", alu_start, 0); check("arst_rv", result_valid, 0);
    check("arst_disp", display_value, 0);
    @(negedge clk_in);
    reset = 0;
    pulse_done(16'hFFFF);
    @(negedge clk_in);
    check("late_done", result_valid, 0);

    check("launch_q_empty", launch_q.size(), 0);
    check("result_q_empty", result_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_entry_sequencer.md
# alu_entry_sequencer

Keypad-entry sequencer and ALU controller for the calculator datapath. It shares the keypad key code and the one-cycle `BTNC` press pulse with the ALU state FSM, and reads the FSM's 2-bit `estado_alu`. From these it assembles hex operands A and B, latches the operation, and launches the ALU with a start/done handshake. It captures the result and drives the value shown by the VGA display path.

## Interface
- `WIDTH`, default 16: operand and result width in bits. Must be a multiple of 4 and at least 8. Digit capacity is `WIDTH/4`.
- `clk_in`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `valor`  in  5  key code. `5'b0xxxx` is hex digit `valor[3:0]`; EXE=`5'b10011`, CLR=`5'b10111`, CE=`5'b10110`; all other codes are ignored.
- `BTNC`  in  1  key-press pulse, high for exactly one cycle per press. `valor` is valid while it is high.
- `estado_alu`  in  2  ALU FSM state, sampled on the same edge as the press: W1=0, W2=1, WOP=2, GOP=3.
- `alu_a`, `alu_b`  out  WIDTH  operand registers A and B.
- `alu_op`  out  2  operation: 0=ADD, 1=SUB, 2=AND, 3=OR.
- `alu_start`  out  1  one-cycle launch pulse to the ALU.
- `alu_done`  in  1  one-cycle completion pulse from the ALU; `alu_result` is valid with it.
- `alu_result`  in  WIDTH  ALU output.
- `busy`  out  1  an operation is outstanding.
- `result`  out  WIDTH  captured result.
- `result_valid`  out  1  `result` holds a completed result.
- `display_value`  out  WIDTH  registered display mux.

## Operation
- The block acts only on cycles with `BTNC`=1, using the `estado_alu` value sampled on that edge. The FSM transitions on the same edge.
- **W1:**
  - digit: A ← {A[WIDTH-5:0], digit}, `cntA`++. Once `cntA`=WIDTH/4, further digits are ignored.
  - CE: A←0, `cntA`←0.
- **W2:**
  - digit: same rule, applied to B and `cntB`.
  - CE: B←0, `cntB`←0. A and `cntA` are kept, so further W1 digits append to A.
- **WOP:**
  - digits 0–3: `alu_op` ← digit. Digits 4–F are ignored.
  - EXE: sets `launch_req`.
  - CE: `alu_op`←ADD.
- **GOP:**
  - CE: `result_valid`←0 and the operation aborts.
  - EXE: clears A, B, counts, `alu_op`, `result_valid` (see Configuration).
- **CLR in any state:** clears A, B, counts, `alu_op`, `result`, `result_valid`, and aborts.
- **Launch:**
  - If `launch_req`=1 and `drop_pending`=0: `alu_start`=1 for one cycle, then `busy`←1 and `launch_req`←0.
  - If `drop_pending`=1: `launch_req` is held until the drop completes.
- **Completion:**
  - `alu_done` with `busy`=1 and `drop_pending`=0: `result`←`alu_result`, `result_valid`←1, `busy`←0.
- **Abort (CLR, or CE in GOP) while `busy`=1:**
  - `busy`←0 and `drop_pending`←1.
  - The next `alu_done` is discarded and clears `drop_pending`.
  - Abort with `busy`=0 only clears `launch_req`.
- **Display mux** (`display_value`):
  - W1 → A; W2 → B; WOP → zero-extended `alu_op`.
  - GOP → `result` if `result_valid`, else 0.
  - The mux uses the current `estado_alu`.
- **Precedence** on a single press: CLR > CE > EXE > digit. Only one key code is present per press.

## Timing
- Reset values: A, B, `result`, `display_value`=0; `alu_op`=ADD; `alu_start`, `busy`, `result_valid`=0; `launch_req`, `drop_pending`, counts=0.
- Register updates (A, B, `alu_op`, counts) are visible the cycle after the press edge.
- `display_value` lags `estado_alu`/register changes by one cycle.
- Launch timeline:
  - EXE in WOP at edge N.
  - `alu_start` high in cycle N+1 (edge N+1 to N+2); `busy` high from edge N+2.
  - `alu_a`, `alu_b`, `alu_op` are stable from N+1 and are frozen while `busy`=1. Digit and op presses are ignored while busy.
- `alu_done` with `result` capture: `result_valid` is high on the next edge.
- `alu_done` arriving in the same cycle as an abort press: the abort wins, the result is discarded, and `drop_pending` is not set.
- `alu_done` with `busy`=0 and `drop_pending`=0 is ignored.
- Asynchronous reset mid-operation clears everything. Any late `alu_done` is then ignored.

## Configuration
- `ALU_RESULT_CHAIN_EN` defined:
  - EXE in GOP with `result_valid`=1 loads A←`result` and `cntA`←WIDTH/4, so A is full and further digits are ignored until CE.
  - B, `alu_op`, and `result_valid` are cleared.
- Undefined: EXE in GOP clears A as well.

## Test plan
- Reset, then press digits 1,2,3,4,5 in W1 → A=16'h1234 (fifth digit ignored), `display_value`=16'h1234.
- A=16'h00FF, B=16'h0001; op digit 1 in WOP; EXE → one `alu_start` pulse with `alu_op`=1. ALU returns 16'h00FE after 3 cycles → `result`=16'h00FE, `result_valid`=1, `busy`=0.
- Digits A,B in W2, then CE → B=0 and A unchanged. Then op digit 7 in WOP → `alu_op` unchanged.
- Launch, then CLR before `alu_done`. Stale done arrives. Relaunch with A=2, B=3, ADD → stale done discarded, second `alu_start` issued only after the stale done, `result`=5.
- With `ALU_RESULT_CHAIN_EN`: result 16'h0005, EXE in GOP → A=16'h0005, B=0, and a digit press leaves A unchanged. Without the macro → A=0.
- Assert `reset` while `busy`=1 → all outputs 0 and `alu_op`=ADD immediately. A following `alu_done` does not set `result_valid`.
